// File: rtl/game_state_ctrl.sv
// Round controller for flappy-bird: debounces the flap button, sequences
// IDLE/PLAY/DYING/OVER and keeps round score plus session high score.
module game_state_ctrl #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int DEATH_TICKS    = 60,
  parameter int SCORE_MAX      = 999
) (
  input  logic       gameClk,
  input  logic       reset_n,
  input  logic       btn_raw,
  input  logic       hitColumn,
  input  logic       passColumn,
  output logic       flap,
  output logic       finished,
  output logic       round_rst,
  output logic       playing,
  output logic [9:0] score,
  output logic [9:0] high_score,
  output logic       new_high
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam logic [3:0] DB_CNT     = 4'(DEBOUNCE_TICKS);
  localparam logic [7:0] DEATH_LOAD = 8'(DEATH_TICKS - 1);
  localparam logic [9:0] SMAX       = 10'(SCORE_MAX);

  logic       sync1_q, sync2_q;
  logic [3:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       press_q, press_d;

  state_t     state_q, state_d;
  logic [7:0] death_q, death_d;
  logic [9:0] score_q, score_d;
  logic [9:0] high_q, high_d;
  logic       new_high_q, new_high_d;
  logic       flap_q, flap_d;
  logic       round_rst_q, round_rst_d;
  logic       playing_q, playing_d;
  logic       finished_q, finished_d;

  // Debounce: accept a new level only after DB_CNT consecutive differing samples
  always_comb begin
    cnt_d   = 4'd0;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d   = 4'd0;
      level_d = level_q;
    end else if (cnt_q + 4'd1 == DB_CNT) begin
      cnt_d   = 4'd0;
      level_d = ~level_q;
    end else begin
      cnt_d   = cnt_q + 4'd1;
      level_d = level_q;
    end
    press_d = level_d & ~level_q;
  end

  // Button synchroniser, debounce state and press pulse register
  always_ff @(posedge gameClk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= 4'd0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  // Round sequencing; status flags are derived from the next state so they stay registered
  always_comb begin
    state_d     = state_q;
    death_d     = death_q;
    score_d     = score_q;
    high_d      = high_q;
    new_high_d  = new_high_q;
    flap_d      = 1'b0;
    round_rst_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_q) begin
          state_d = S_PLAY;
          flap_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        flap_d = press_q;
        if (hitColumn) begin
          state_d = S_DYING;
          death_d = DEATH_LOAD;
        end else if (passColumn && (score_q < SMAX)) begin
          score_d = score_q + 10'd1;
        end else begin
          score_d = score_q;
        end
      end
      S_DYING: begin
        if (death_q == 8'd0) begin
          state_d = S_OVER;
          if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
          end else begin
            high_d = high_q;
          end
        end else begin
          death_d = death_q - 8'd1;
        end
      end
      S_OVER: begin
        if (press_q) begin
          state_d     = S_IDLE;
          round_rst_d = 1'b1;
          score_d     = 10'd0;
          new_high_d  = 1'b0;
        end else begin
          state_d = S_OVER;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    playing_d  = (state_d == S_PLAY);
    finished_d = (state_d == S_DYING) || (state_d == S_OVER);
  end

  // FSM state and registered outputs
  always_ff @(posedge gameClk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      death_q     <= 8'd0;
      score_q     <= 10'd0;
      high_q      <= 10'd0;
      new_high_q  <= 1'b0;
      flap_q      <= 1'b0;
      round_rst_q <= 1'b0;
      playing_q   <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      death_q     <= death_d;
      score_q     <= score_d;
      high_q      <= high_d;
      new_high_q  <= new_high_d;
      flap_q      <= flap_d;
      round_rst_q <= round_rst_d;
      playing_q   <= playing_d;
      finished_q  <= finished_d;
    end
  end

  assign flap       = flap_q;
  assign finished   = finished_q;
  assign round_rst  = round_rst_q;
  assign playing    = playing_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign new_high   = new_high_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Randomised + directed bench for game_state_ctrl against a behavioural round model;
// a second instance with SCORE_MAX=3 shares stimulus to exercise saturation.
module tb_game_state_ctrl;

  localparam int DB = 4;
  localparam int DT = 60;

  logic gameClk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_raw = 1'b0, hitColumn = 1'b0, passColumn = 1'b0;
  logic flap, finished, round_rst, playing, new_high;
  logic [9:0] score, high_score;
  logic flap2, finished2, round_rst2, playing2, new_high2;
  logic [9:0] score2, high_score2;

  game_state_ctrl dut (
    .gameClk(gameClk), .reset_n(reset_n), .btn_raw(btn_raw),
    .hitColumn(hitColumn), .passColumn(passColumn),
    .flap(flap), .finished(finished), .round_rst(round_rst), .playing(playing),
    .score(score), .high_score(high_score), .new_high(new_high)
  );

  game_state_ctrl #(.SCORE_MAX(3)) dut2 (
    .gameClk(gameClk), .reset_n(reset_n), .btn_raw(btn_raw),
    .hitColumn(hitColumn), .passColumn(passColumn),
    .flap(flap2), .finished(finished2), .round_rst(round_rst2), .playing(playing2),
    .score(score2), .high_score(high_score2), .new_high(new_high2)
  );

  always #5 gameClk = ~gameClk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: button chain, round mode (0 idle,1 play,2 dying,3 over)
  int m_s1, m_s2, m_lvl, m_run, m_press;
  int m_mode, m_dcnt, m_flap, m_rr;
  int m_score[2], m_high[2], m_nh[2];
  int smax[2];
  bit m_valid = 1'b0;

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_press = 0;
    m_mode = 0; m_dcnt = 0; m_flap = 0; m_rr = 0;
    for (int i = 0; i < 2; i++) begin
      m_score[i] = 0; m_high[i] = 0; m_nh[i] = 0;
    end
    smax[0] = 999; smax[1] = 3;
    m_valid = 1'b1;
  endfunction

  function automatic void model_step(input int b, input int hit, input int pas);
    int pr = m_press;
    int np = 0;
    if (m_s2 != m_lvl) begin
      if (m_run + 1 == DB) begin
        m_lvl = 1 - m_lvl;
        m_run = 0;
        np = m_lvl;
      end else begin
        m_run++;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1; m_s1 = b; m_press = np;
    m_flap = 0; m_rr = 0;
    case (m_mode)
      0: if (pr != 0) begin m_mode = 1; m_flap = 1; end
      1: begin
        m_flap = pr;
        if (hit != 0) begin
          m_mode = 2; m_dcnt = DT - 1;
        end else if (pas != 0) begin
          for (int i = 0; i < 2; i++)
            if (m_score[i] < smax[i]) m_score[i]++;
        end
      end
      2: begin
        if (m_dcnt == 0) begin
          m_mode = 3;
          for (int i = 0; i < 2; i++)
            if (m_score[i] > m_high[i]) begin m_high[i] = m_score[i]; m_nh[i] = 1; end
        end else begin
          m_dcnt--;
        end
      end
      default: if (pr != 0) begin
        m_mode = 0; m_rr = 1;
        for (int i = 0; i < 2; i++) begin m_score[i] = 0; m_nh[i] = 0; end
      end
    endcase
  endfunction

  // Compare process: advance model on every edge/reset, check both DUTs 1ns later
  always begin
    @(posedge gameClk or negedge reset_n);
    if (reset_n !== 1'b1) model_reset();
    else if (m_valid) model_step(int'(btn_raw), int'(hitColumn), int'(passColumn));
    #1;
    if (m_valid) begin
      check("m_flap", flap, m_flap);
      check("m_round_rst", round_rst, m_rr);
      check("m_playing", playing, (m_mode == 1) ? 1 : 0);
      check("m_finished", finished, (m_mode >= 2) ? 1 : 0);
      check("m_score", score, m_score[0]);
      check("m_high", high_score, m_high[0]);
      check("m_new_high", new_high, m_nh[0]);
      check("m2_flap", flap2, m_flap);
      check("m2_finished", finished2, (m_mode >= 2) ? 1 : 0);
      check("m2_score", score2, m_score[1]);
      check("m2_high", high_score2, m_high[1]);
      check("m2_new_high", new_high2, m_nh[1]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge gameClk);
  endtask

  task automatic pass_pulse();
    passColumn = 1'b1; cyc(1); passColumn = 1'b0; cyc(1);
  endtask

  task automatic press_measure(input string nm);
    int first = 0;
    int cnt = 0;
    btn_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge gameClk);
      if (flap) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    check({nm, "_latency"}, first, 7);
    check({nm, "_count"}, cnt, 1);
  endtask

  initial begin
    int k, fl, rr, seg, g;
    #12;
    check("rst_flap", flap, 0);
    check("rst_score", score, 0);
    check("rst_high", high_score, 0);
    check("rst_finished", finished, 0);
    @(negedge gameClk);
    reset_n = 1'b1;
    cyc(2);

    // Bouncing input must never be accepted
    fl = 0;
    for (int i = 0; i < 20; i++) begin
      btn_raw = (i < 10) ? ((i % 2) == 0) : 1'b0;
      cyc(1);
      if (flap) fl++;
    end
    check("bounce_flap", fl, 0);
    check("bounce_playing", playing, 0);

    press_measure("press1");
    check("press1_playing", playing, 1);
    btn_raw = 1'b0; cyc(10);
    press_measure("press2");
    btn_raw = 1'b0; cyc(10);

    repeat (5) pass_pulse();
    check("r1_score", score, 5);
    check("r1_score_sat", score2, 3);

    hitColumn = 1'b1;
    @(negedge gameClk);
    hitColumn = 1'b0;
    k = 1;
    check("hit_finished", finished, 1);
    check("hit_playing", playing, 0);
    check("hit_score", score, 5);
    fl = 0;
    while (!new_high && k < 200) begin
      if (k == 5) btn_raw = 1'b1;
      if (k == 20) btn_raw = 1'b0;
      @(negedge gameClk);
      k++;
      if (flap) fl++;
    end
    check("dying_len", k, DT + 1);
    check("dying_flap", fl, 0);
    check("r1_high", high_score, 5);
    check("r1_high_sat", high_score2, 3);
    check("r1_new_high2", new_high2, 1);

    btn_raw = 1'b1;
    rr = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge gameClk);
      if (round_rst) begin
        rr++;
        check("rst_round_score", score, 0);
        check("rst_round_nh", new_high, 0);
        check("rst_round_high", high_score, 5);
      end
    end
    check("round_rst_count", rr, 1);
    btn_raw = 1'b0; cyc(10);
    check("idle_after_rst", playing, 0);

    press_measure("press3");
    btn_raw = 1'b0; cyc(10);
    repeat (3) pass_pulse();
    check("r2_score", score, 3);
    hitColumn = 1'b1; passColumn = 1'b1; cyc(1);
    hitColumn = 1'b0; passColumn = 1'b0;
    check("r2_hitpass_score", score, 3);
    check("r2_finished", finished, 1);
    cyc(70);
    check("r2_high", high_score, 5);
    check("r2_new_high", new_high, 0);
    check("r2_new_high2", new_high2, 0);
    btn_raw = 1'b1; cyc(10); btn_raw = 1'b0; cyc(10);

    // Random phase: held button segments, sparse hits, frequent passes
    seg = 0;
    for (int i = 0; i < 1500; i++) begin
      if (seg == 0) begin
        btn_raw = 1'($urandom_range(0, 1));
        seg = $urandom_range(1, 12);
      end
      seg--;
      hitColumn  = ($urandom_range(0, 39) == 0);
      passColumn = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    hitColumn = 1'b0; passColumn = 1'b0; btn_raw = 1'b0;
    cyc(10);

    g = 0;
    while (!playing && g < 25) begin
      btn_raw = 1'b1; cyc(8); btn_raw = 1'b0; cyc(8);
      g++;
    end
    check("reach_play", playing, 1);
    pass_pulse();
    pass_pulse();

    #2 reset_n = 1'b0;
    #1;
    check("arst_playing", playing, 0);
    check("arst_finished", finished, 0);
    check("arst_flap", flap, 0);
    check("arst_round_rst", round_rst, 0);
    check("arst_score", score, 0);
    check("arst_high", high_score, 0);
    check("arst_new_high", new_high, 0);
    check("arst_score2", score2, 0);
    check("arst_high2", high_score2, 0);
    cyc(3);
    reset_n = 1'b1;
    cyc(3);
    check("post_rst_playing", playing, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Round controller for the flappy-bird game, directly upstream of `birdMovement`, `columnGen` and `calcScore`. Conditions the raw flap button and sequences a round through idle, play, death and game-over states. Produces the flap pulse, freeze flag and per-round restart, and keeps the round score and session high score. Consumes `hitColumn` and `passColumn` from collision detection and column generation.

## Interface
- `DEBOUNCE_TICKS`, default 4: consecutive identical samples required to accept a button level change (range 1–15).
- `DEATH_TICKS`, default 60: `gameClk` cycles spent in DYING before OVER (range 1–255).
- `SCORE_MAX`, default 999: saturation value for `score` and `high_score` (at most 1023).
- `gameClk`  in  1  game tick clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  1  unsynchronised flap/start pushbutton, active-high.
- `hitColumn`  in  1  level; bird overlaps a pipe or the ground this tick.
- `passColumn`  in  1  single-cycle pulse; bird cleared a pipe.
- `flap`  out  1  single-cycle pulse to `birdMovement`.
- `finished`  out  1  freeze; high in DYING and OVER.
- `round_rst`  out  1  single-cycle pulse; resets bird, columns and score datapath.
- `playing`  out  1  high in PLAY only.
- `score`  out  10  current round score, binary.
- `high_score`  out  10  best score since `reset_n`.
- `new_high`  out  1  high in OVER when the finished round set a new high score.

## Operation
- Button path:
  - 2-flop synchroniser.
  - 4-bit debounce counter. The counter resets whenever the synchronised sample equals the accepted level. Otherwise it increments, and the accepted level flips when the count reaches `DEBOUNCE_TICKS`.
  - `press` is a 1-cycle pulse on each accepted 0→1 transition. Holding the button produces exactly one `press`.
- FSM states: IDLE, PLAY, DYING, OVER. After reset the FSM is in IDLE.
- IDLE:
  - `press` → PLAY, with `flap` asserted the same cycle.
  - `hitColumn` and `passColumn` are ignored.
- PLAY:
  - `flap` = `press`.
  - `passColumn` increments `score`, saturating at `SCORE_MAX`.
  - `hitColumn` → DYING and loads the death counter with `DEATH_TICKS`−1.
  - If `hitColumn` and `passColumn` occur in the same cycle, the hit wins and `score` does not increment.
- DYING:
  - `press`, `passColumn` and `hitColumn` are ignored; `flap` stays 0.
  - The death counter decrements each cycle. When it is 0 → OVER.
  - On that same edge, if `score` > `high_score`: `high_score` ← `score` and `new_high` ← 1.
- OVER:
  - `score` holds.
  - `press` → IDLE with `round_rst` pulsed for 1 cycle, `score` ← 0 and `new_high` ← 0.
- `high_score` is cleared only by `reset_n`.
- Reset values: FSM IDLE, `flap` 0, `finished` 0, `round_rst` 0, `playing` 0, `score` 0, `high_score` 0, `new_high` 0. Synchroniser, debounce counter, accepted level and death counter are all 0.

## Timing
- All outputs are registered.
- Latency from a `btn_raw` rise to `flap`/`press`: 2 synchroniser cycles + `DEBOUNCE_TICKS` cycles + 1 cycle. With defaults this is 7 `gameClk` edges, for a clean, stable input.
- `passColumn` in PLAY updates `score` on the next edge.
- `hitColumn` sampled in PLAY raises `finished` on the next edge; `playing` falls on the same edge.
- `finished` stays high for exactly `DEATH_TICKS` cycles in DYING, then continues high in OVER.
- `high_score` updates on the DYING→OVER edge.
- `round_rst` is high during the first IDLE cycle after OVER; `score` reads 0 on that same cycle.
- `reset_n` low at any time forces reset values immediately, independent of `gameClk`. A round in progress is abandoned and `high_score` is lost.
- `reset_n` deassertion is assumed synchronous to `gameClk` by the top level.
- A `press` being debounced across a state transition is delivered in the new state. For example, a press whose debounce completes in OVER triggers the restart.

## Test plan
- Reset, then hold `btn_raw`=1 for 20 cycles → exactly one `flap`, 7 edges after the rise; state PLAY; `playing`=1. Release and repress → a second `flap` 7 edges later.
- Bounce: toggle `btn_raw` every cycle for 10 cycles, then hold 0 → no `flap`, no state change.
- In PLAY, 5 `passColumn` pulses, then `hitColumn` → `score`=5 and `finished`=1 on the next edge. DYING lasts 60 cycles → OVER, `high_score`=5, `new_high`=1.
- Same cycle `hitColumn`+`passColumn` with `score`=3 → DYING, `score` stays 3. Presses during DYING produce no `flap`.
- From OVER, `press` → `round_rst` 1-cycle pulse, `score`=0, `new_high`=0, `high_score` still 5. A second round scoring 2 → `high_score`=5, `new_high`=0.
- `SCORE_MAX`=3 with 6 passes → `score`=3. Assert `reset_n`=0 mid-PLAY → all outputs at reset values without a clock edge.
